// File: rtl/div_result_fifo.sv
// First-word-fall-through result FIFO behind div: stores {quotient, remainder} pairs,
// presents the oldest with valid/ready, and drops and flags arrivals when no slot is free.
module div_result_fifo #(
  parameter int DEPTH = 4,
  parameter int QW    = 8,
  parameter int RW    = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_in_valid,
  input  logic [QW-1:0]              i_q,
  input  logic [RW-1:0]              i_r,
  input  logic                       i_out_ready,
  input  logic                       i_clr_ovf,
  output logic                       o_out_valid,
  output logic [QW-1:0]              o_q,
  output logic [RW-1:0]              o_r,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_overflow,
  output logic [50:0]                number
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [QW-1:0] mem_q_r [DEPTH];
  logic [RW-1:0] mem_r_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          ovf_r;

  logic valid_s;
  logic full_s;
  logic pop_s;
  logic push_s;
  logic drop_s;

  assign valid_s = (count_r != {CW{1'b0}});
  assign full_s  = (count_r == CW'(DEPTH));
  assign pop_s   = valid_s & i_out_ready;
  assign push_s  = i_in_valid & (~full_s | pop_s);
  assign drop_s  = i_in_valid & full_s & ~pop_s;

  // Pointer, occupancy and sticky overflow state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + CW'(1);
      end else if (pop_s && !push_s) begin
        count_r <= count_r - CW'(1);
      end
      // A drop in the same cycle as a clear must leave the flag set.
      if (drop_s) begin
        ovf_r <= 1'b1;
      end else if (i_clr_ovf) begin
        ovf_r <= 1'b0;
      end
    end
  end

  // Result storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q_r[wr_ptr_r] <= i_q;
      mem_r_r[wr_ptr_r] <= i_r;
    end
  end

  // Head presentation, zeroed while empty.
  always_comb begin
    o_q = {QW{1'b0}};
    o_r = {RW{1'b0}};
    if (valid_s) begin
      o_q = mem_q_r[rd_ptr_r];
      o_r = mem_r_r[rd_ptr_r];
    end else begin
      o_q = {QW{1'b0}};
      o_r = {RW{1'b0}};
    end
  end

  assign o_out_valid = valid_s;
  assign o_count     = count_r;
  assign o_full      = full_s;
  assign o_overflow  = ovf_r;
  // Pure RTL with no instantiated library cells.
  assign number      = 51'd0;

endmodule

// File: tb/tb_div_result_fifo.sv
// Scoreboard bench for div_result_fifo: directed pushes queue expected results,
// a negedge monitor compares every accepted head entry against the queue.
module tb_div_result_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_in_valid = 1'b0;
  logic [7:0]  i_q = 8'd0;
  logic [4:0]  i_r = 5'd0;
  logic        i_out_ready = 1'b0;
  logic        i_clr_ovf = 1'b0;
  logic        o_out_valid;
  logic [7:0]  o_q;
  logic [4:0]  o_r;
  logic [2:0]  o_count;
  logic        o_full;
  logic        o_overflow;
  logic [50:0] number;

  int vectors = 0;
  int miscompares = 0;
  logic [12:0] exp_q[$];

  div_result_fifo #(.DEPTH(4), .QW(8), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n), .i_in_valid(i_in_valid), .i_q(i_q), .i_r(i_r),
    .i_out_ready(i_out_ready), .i_clr_ovf(i_clr_ovf), .o_out_valid(o_out_valid),
    .o_q(o_q), .o_r(o_r), .o_count(o_count), .o_full(o_full),
    .o_overflow(o_overflow), .number(number)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] q, input logic [4:0] r, input bit store);
    i_in_valid = 1'b1;
    i_q = q;
    i_r = r;
    if (store) exp_q.push_back({q, r});
    step();
    i_in_valid = 1'b0;
  endtask

  task automatic drain();
    i_out_ready = 1'b1;
    for (int i = 0; i < 20 && o_out_valid; i++) step();
    chk("drain_done", {31'd0, o_out_valid}, 32'd0);
    i_out_ready = 1'b0;
  endtask

  // Monitor: every head accepted this cycle must match the oldest expected result.
  initial begin
    logic [12:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && o_out_valid && i_out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", {19'd0, o_q, o_r}, 32'd0);
          if (o_q == 8'd0 && o_r == 5'd0) chk("unexpected_pop_empty_sb", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("head_q", {24'd0, o_q}, {24'd0, e[12:5]});
          chk("head_r", {27'd0, o_r}, {27'd0, e[4:0]});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state
    #12;
    chk("rst_valid", {31'd0, o_out_valid}, 32'd0);
    chk("rst_q", {24'd0, o_q}, 32'd0);
    chk("rst_r", {27'd0, o_r}, 32'd0);
    chk("rst_count", {29'd0, o_count}, 32'd0);
    chk("rst_full", {31'd0, o_full}, 32'd0);
    chk("rst_ovf", {31'd0, o_overflow}, 32'd0);
    rst_n = 1'b1;
    step();

    // 2: single result, 1-cycle latency, popped immediately
    i_out_ready = 1'b1;
    send(8'd28, 5'd4, 1'b1);
    chk("t2_valid", {31'd0, o_out_valid}, 32'd1);
    chk("t2_q", {24'd0, o_q}, 32'd28);
    step();
    chk("t2_empty", {31'd0, o_out_valid}, 32'd0);
    i_out_ready = 1'b0;

    // 3: five results into four slots, last dropped
    send(8'd3, 5'd1, 1'b1);
    send(8'd6, 5'd2, 1'b1);
    send(8'd4, 5'd2, 1'b1);
    send(8'd4, 5'd4, 1'b1);
    send(8'd4, 5'd6, 1'b0);
    chk("t3_count", {29'd0, o_count}, 32'd4);
    chk("t3_full", {31'd0, o_full}, 32'd1);
    chk("t3_ovf", {31'd0, o_overflow}, 32'd1);
    chk("t3_head_stable", {24'd0, o_q}, 32'd3);

    // 5: clear coinciding with a drop loses to the drop
    i_clr_ovf = 1'b1;
    send(8'd1, 5'd1, 1'b0);
    chk("t5_set_wins", {31'd0, o_overflow}, 32'd1);
    step();
    i_clr_ovf = 1'b0;
    chk("t5_cleared", {31'd0, o_overflow}, 32'd0);
    chk("t5_count", {29'd0, o_count}, 32'd4);
    drain();

    // 4: full with simultaneous pop and push keeps count at four
    send(8'd11, 5'd1, 1'b1);
    send(8'd12, 5'd2, 1'b1);
    send(8'd13, 5'd3, 1'b1);
    send(8'd14, 5'd4, 1'b1);
    i_out_ready = 1'b1;
    send(8'd9, 5'd9, 1'b1);
    i_out_ready = 1'b0;
    chk("t4_count", {29'd0, o_count}, 32'd4);
    chk("t4_ovf", {31'd0, o_overflow}, 32'd0);
    chk("t4_head", {24'd0, o_q}, 32'd12);
    drain();

    // 6: streaming with pointer wrap, then reset with entries held
    i_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) send(8'(20 + i), 5'(i), 1'b1);
    i_out_ready = 1'b0;
    send(8'd30, 5'd10, 1'b1);
    chk("t6_count", {29'd0, o_count}, 32'd2);
    chk("t6_head", {24'd0, o_q}, 32'd25);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_count", {29'd0, o_count}, 32'd0);
    chk("t6_rst_valid", {31'd0, o_out_valid}, 32'd0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    step();
    send(8'd7, 5'd3, 1'b1);
    chk("t6_after_rst_q", {24'd0, o_q}, 32'd7);
    chk("t6_after_rst_r", {27'd0, o_r}, 32'd3);
    drain();

    chk("sb_empty", exp_q.size(), 32'd0);
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
